// File: rtl/issue_execute_fifo.sv
// issue_execute_fifo: first-word-fall-through queue from issue to one execute unit
//   clk, rst           : clock and synchronous active-high reset
//   data_in, push      : enqueue side, accepted only while not full
//   full               : queue holds DEPTH entries
//   data_out           : head entry, zero when empty
//   data_out_valid     : queue non-empty
//   pop                : dequeue head, ignored when empty
//   flush              : commit flush, discards every entry
//   count              : current occupancy 0..DEPTH
package issue_execute_pkg;
    typedef struct packed {
        logic [5:0]  rob_id;
        logic [3:0]  alu_op;
        logic [4:0]  rd;
        logic [31:0] src_a;
        logic [31:0] src_b;
    } issue_execute_pack_t;
endpackage

module issue_execute_fifo
    import issue_execute_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  issue_execute_pack_t        data_in,
    input  logic                       push,
    output logic                       full,
    output issue_execute_pack_t        data_out,
    output logic                       data_out_valid,
    input  logic                       pop,
    input  logic                       flush,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    issue_execute_pack_t r_mem [DEPTH];
    logic [AW-1:0]       r_rptr;
    logic [AW-1:0]       r_wptr;
    logic [CW-1:0]       r_cnt;
    logic                w_do_push;
    logic                w_do_pop;

    assign full           = (r_cnt == CW'(DEPTH));
    assign data_out_valid = (r_cnt != '0);
    assign data_out       = data_out_valid ? r_mem[r_rptr] : '0;
    assign count          = r_cnt;
    assign w_do_push      = push && !full && !flush;
    assign w_do_pop       = pop && data_out_valid && !flush;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_rptr <= '0;
            r_wptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + AW'(1);
            if (w_do_pop)  r_rptr <= r_rptr + AW'(1);
            r_cnt <= r_cnt + CW'(w_do_push) - CW'(w_do_pop);
        end
    end

    // Storage needs no reset; slots are only read while counted as occupied.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wptr] <= data_in;
    end
endmodule
